button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Turns one raw push-button (flip, rst, mode keys) into clean clk-domain events for the ping-pong counter.
//  Pipeline: synchroniser -> tick-sampled debouncer -> press/release/hold FSM.
//  Outputs are single-clk pulses, so consumers never need their own edge detection or clock-enable logic.
//  Sits between the board pins and the counter. Samples on the refresh tick produced by the clock divider.
// PARAMETERS
//  ACTIVE_LOW      0    1: the button pin reads 0 when pressed; it is inverted before the synchroniser
//  SYNC_STAGES     2    synchroniser depth in flops; legal range 2..4
//  DEBOUNCE_TICKS  4    consecutive disagreeing ticks required to accept a level change; >=1
//  HOLD_TICKS      500  ticks with the key held in PRESSED before entering HELD; >=1
//  REPEAT_TICKS    100  ticks between auto-repeat pulses in HELD; 0 disables repeat
// PORTS
//  clk         in   1  system clock; every register in this block is clocked by it
//  rst_n       in   1  asynchronous, active-low reset
//  tick        in   1  one-clk sample strobe from the clock divider (1 ms nominal)
//  pb          in   1  raw, asynchronous button pin
//  pb_level    out  1  debounced level; 1 = pressed
//  pb_press    out  1  one-clk pulse on an accepted press
//  pb_release  out  1  one-clk pulse on an accepted release
//  pb_repeat   out  1  one-clk pulse on entry to HELD, then every REPEAT_TICKS ticks while held
//  hold        out  1  level; 1 while the FSM is in HELD
// BEHAVIOUR
//  Reset: all outputs 0, synchroniser flops 0, counters 0, FSM in IDLE. Nothing is gated by tick.
//  Synchroniser
//   - Input is pb XOR ACTIVE_LOW, passed through a SYNC_STAGES flop chain clocked on every clk.
//   - s = the last stage of that chain.
//  Debouncer (acts only in cycles where tick=1)
//   - If s == pb_level: deb_cnt clears to 0.
//   - Otherwise deb_cnt increments.
//   - When deb_cnt would reach DEBOUNCE_TICKS, pb_level toggles and deb_cnt clears.
//   - Ticks with tick=0 hold deb_cnt unchanged.
//  Event timing
//   - pb_press, pb_release and pb_repeat are registered.
//   - Each asserts on the same clk edge that updates pb_level (or the hold counter) and lasts exactly one clk.
//   - Worst-case latency from a stable pin change to the pulse is SYNC_STAGES clk + DEBOUNCE_TICKS ticks + 1 clk.
//  FSM states: IDLE, PRESSED, HELD
//   - IDLE -> PRESSED when pb_level rises; pb_press=1; hold_cnt cleared.
//   - PRESSED: hold_cnt increments on tick. When it reaches HOLD_TICKS: go to HELD, hold=1, pb_repeat=1,
//     hold_cnt cleared.
//   - HELD, REPEAT_TICKS != 0: hold_cnt increments on tick; on reaching REPEAT_TICKS, pb_repeat=1 and
//     hold_cnt clears.
//   - HELD, REPEAT_TICKS == 0: no further pb_repeat pulses.
//   - PRESSED or HELD -> IDLE when pb_level falls: pb_release=1, hold=0 on the same edge, hold_cnt cleared.
//  Simultaneous events
//   - Release wins over a hold or repeat expiry in the same cycle: pb_release=1 and pb_repeat=0.
//   - pb_press and pb_release never assert in the same cycle, because pb_level changes at most once per tick.
//  Boundaries and widths
//   - deb_cnt is $clog2(DEBOUNCE_TICKS+1) bits.
//   - hold_cnt is $clog2(max(HOLD_TICKS,REPEAT_TICKS)+1) bits.
//   - Counters never wrap: they saturate or clear as described above.
//  Reset mid-press
//   - All outputs drop asynchronously.
//   - If the key is still down after rst_n deasserts: after DEBOUNCE_TICKS ticks, exactly one pb_press
//     is emitted and the hold timing restarts from 0.
//  Glitch rejection: a pin pulse shorter than DEBOUNCE_TICKS consecutive ticks never changes pb_level
//  and never produces any pulse.
// STRUCTURE
//  Shared package
//   - FSM state encoding: IDLE=2'd0, PRESSED=2'd1, HELD=2'd2; 2'd3 is illegal and recovers to IDLE.
//   - Default tick-count constants shared with the clock divider.
//  Sub-module: bit_synchronizer (parameter STAGES; ports clk, rst_n, d, q). Reused for every asynchronous pin.
//  This file contains the debouncer and the FSM, with separate sequential and combinational blocks.
// TESTING (bench params: DEBOUNCE_TICKS=4, HOLD_TICKS=10, REPEAT_TICKS=3, tick every 5 clk)
//  1. pb held at 1 for 40 clk
//     -> pb_level rises at tick 4, with a single pb_press in the same cycle; no other pulses.
//  2. pb toggled 1/0 every 7 clk for 100 clk
//     -> pb_level stays 0; press, release and repeat stay 0 throughout.
//  3. pb held 1 for 25 ticks
//     -> press at tick 4; hold=1 and pb_repeat at tick 14; further pb_repeat at ticks 17, 20, 23, 26 if still held.
//  4. pb released at tick 20 in scenario 3
//     -> pb_release at tick 24, hold falls on the same edge; no repeat after the release begins.
//  5. rst_n pulsed low at tick 16 with pb held, then released
//     -> all outputs 0 immediately; one new pb_press 4 ticks after reset; hold re-enters 10 ticks later.
//  6. ACTIVE_LOW=1 with pb driven 0
//     -> identical output sequence to scenario 1.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared FSM encoding, default tick counts and helpers
package button_conditioner_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, HELD = 2'd2} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_TICKS = 4;
  localparam int DEF_HOLD_TICKS = 500;
  localparam int DEF_REPEAT_TICKS = 100;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchroniser for one asynchronous pin
module bit_synchronizer import button_conditioner_pkg::*; #(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  // shift the pin through the flop chain every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r <= '0;
    else r <= {r[STAGES-2:0], d};
  end
  assign q = r[STAGES-1];
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and turn one push-button into press/release/repeat pulses
module button_conditioner import button_conditioner_pkg::*; #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pb,
  output logic pb_level,
  output logic pb_press,
  output logic pb_release,
  output logic pb_repeat,
  output logic hold
);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(max_i(HOLD_TICKS, REPEAT_TICKS) + 1);
  localparam int RL = REPEAT_TICKS == 0 ? 0 : REPEAT_TICKS - 1;
  logic s, lvl_n, rise, fall, press_n, rel_n, rep_n;
  logic [DW-1:0] deb_cnt, deb_n;
  logic [HW-1:0] hold_cnt, hc_n;
  state_t st, st_n;
  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .d(pb ^ ACTIVE_LOW),
    .q(s)
  );
  // debouncer: count consecutive disagreeing ticks, toggle the level on the last one
  always_comb begin
    lvl_n = tick && s != pb_level && deb_cnt == DW'(DEBOUNCE_TICKS - 1) ? ~pb_level : pb_level;
    deb_n = !tick ? deb_cnt : (s == pb_level || deb_cnt == DW'(DEBOUNCE_TICKS - 1)) ? '0 : deb_cnt + 1'b1;
    rise = lvl_n & ~pb_level;
    fall = pb_level & ~lvl_n;
  end
  // press/hold/repeat FSM; a falling level always takes priority over timer expiry
  always_comb begin
    st_n = st;
    hc_n = hold_cnt;
    press_n = 1'b0;
    rel_n = 1'b0;
    rep_n = 1'b0;
    case (st)
      IDLE: begin
        if (rise) begin
          st_n = PRESSED;
          hc_n = '0;
          press_n = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          st_n = IDLE;
          hc_n = '0;
          rel_n = 1'b1;
        end else if (tick) begin
          st_n = hold_cnt == HW'(HOLD_TICKS - 1) ? HELD : PRESSED;
          rep_n = hold_cnt == HW'(HOLD_TICKS - 1);
          hc_n = rep_n ? '0 : hold_cnt + 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          st_n = IDLE;
          hc_n = '0;
          rel_n = 1'b1;
        end else if (tick && REPEAT_TICKS != 0) begin
          rep_n = hold_cnt == HW'(RL);
          hc_n = rep_n ? '0 : hold_cnt + 1'b1;
        end
      end
      default: begin
        st_n = IDLE;
        hc_n = '0;
      end
    endcase
  end
  // register level, counters, state and the one-clk event outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_level <= 1'b0;
      deb_cnt <= '0;
      hold_cnt <= '0;
      st <= IDLE;
      pb_press <= 1'b0;
      pb_release <= 1'b0;
      pb_repeat <= 1'b0;
      hold <= 1'b0;
    end else begin
      pb_level <= lvl_n;
      deb_cnt <= deb_n;
      hold_cnt <= hc_n;
      st <= st_n;
      pb_press <= press_n;
      pb_release <= rel_n;
      pb_repeat <= rep_n;
      hold <= st_n == HELD;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: vector table, hand sequences and random run against a tick-level reference model
module tb_button_conditioner;
  localparam int DEB = 4;
  localparam int HLD = 10;
  localparam int REP = 3;
  typedef struct {
    logic pb;
    logic [4:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick = 1'b0;
  logic pb_raw = 1'b0;
  logic pb_inv;
  logic [4:0] o1, o2;
  int checks = 0;
  int failures = 0;
  int n_press, n_rel, n_rep, n_lvl;
  int press_at, hold_at;
  vec_t vec[30];
  logic q[$];
  logic m_lvl, m_press, m_rel, m_rep;
  int dc, since;
  assign pb_inv = ~pb_raw;
  always #5 clk = ~clk;
  button_conditioner #(.ACTIVE_LOW(1'b0), .SYNC_STAGES(2), .DEBOUNCE_TICKS(DEB), .HOLD_TICKS(HLD), .REPEAT_TICKS(REP)) dut_hi (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pb(pb_raw),
    .pb_level(o1[4]), .pb_press(o1[3]), .pb_release(o1[2]), .pb_repeat(o1[1]), .hold(o1[0])
  );
  button_conditioner #(.ACTIVE_LOW(1'b1), .SYNC_STAGES(2), .DEBOUNCE_TICKS(DEB), .HOLD_TICKS(HLD), .REPEAT_TICKS(REP)) dut_lo (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pb(pb_inv),
    .pb_level(o2[4]), .pb_press(o2[3]), .pb_release(o2[2]), .pb_repeat(o2[1]), .hold(o2[0])
  );
  function automatic logic [4:0] mexp();
    return {m_lvl, m_press, m_rel, m_rep, m_lvl && since >= HLD};
  endfunction
  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", name, got, exp, $time);
    end
  endtask
  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, exp, $time);
    end
  endtask
  task automatic mreset();
    q.delete();
    m_lvl = 1'b0;
    m_press = 1'b0;
    m_rel = 1'b0;
    m_rep = 1'b0;
    dc = 0;
    since = -1;
  endtask
  task automatic clr_counts();
    n_press = 0;
    n_rel = 0;
    n_rep = 0;
    n_lvl = 0;
  endtask
  task automatic step(input logic p, input logic t);
    logic s;
    pb_raw = p;
    tick = t;
    @(posedge clk);
    if (!rst_n) mreset();
    else begin
      s = q.size() >= 2 ? q[q.size()-2] : 1'b0;
      q.push_back(p);
      if (q.size() > 2) void'(q.pop_front());
      m_press = 1'b0;
      m_rel = 1'b0;
      m_rep = 1'b0;
      if (t) begin
        if (s == m_lvl) dc = 0;
        else dc++;
        if (dc == DEB) begin
          dc = 0;
          m_lvl = ~m_lvl;
          if (m_lvl) begin
            m_press = 1'b1;
            since = 0;
          end else begin
            m_rel = 1'b1;
            since = -1;
          end
        end else if (m_lvl) begin
          since++;
          m_rep = since == HLD || (REP != 0 && since > HLD && (since - HLD) % REP == 0);
        end
      end
    end
    #1;
    check("model_hi", o1, mexp());
    check("model_lo", o2, mexp());
    n_press += int'(o1[3]);
    n_rel += int'(o1[2]);
    n_rep += int'(o1[1]);
    n_lvl += int'(o1[4]);
  endtask
  task automatic window(input logic p);
    for (int i = 0; i < 4; i++) step(p, 1'b0);
    step(p, 1'b1);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mreset();
    check("reset_hi", o1, 5'b0);
    check("reset_lo", o2, 5'b0);
    step(pb_raw, 1'b0);
    step(pb_raw, 1'b0);
    rst_n = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 30; i++) begin
      int t;
      t = i + 1;
      vec[i].pb = t <= 20;
      vec[i].exp = {t >= 4 && t < 24, t == 4, t == 24, t == 14 || t == 17 || t == 20 || t == 23, t >= 14 && t < 24};
    end
    mreset();
    clr_counts();
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) window(1'b0);
    clr_counts();
    for (int w = 1; w <= 8; w++) begin
      window(1'b1);
      if (w == 3) begin
        check("s1_tick3_hi", o1, 5'b00000);
        check("s1_tick3_lo", o2, 5'b00000);
      end
      if (w == 4) begin
        check("s1_tick4_hi", o1, 5'b11000);
        check("s1_tick4_lo", o2, 5'b11000);
      end
    end
    check_int("s1_presses", n_press, 1);
    check_int("s1_other", n_rel + n_rep, 0);
    for (int i = 0; i < 6; i++) window(1'b0);
    clr_counts();
    for (int c = 0; c < 100; c++) step((c / 7) % 2 == 0, c % 5 == 4);
    check_int("s2_pulses", n_press + n_rel + n_rep, 0);
    check_int("s2_level", n_lvl, 0);
    for (int i = 0; i < 6; i++) window(1'b0);
    for (int i = 0; i < 30; i++) begin
      window(vec[i].pb);
      check("tab_hi", o1, vec[i].exp);
      check("tab_lo", o2, vec[i].exp);
    end
    for (int i = 0; i < 6; i++) window(1'b0);
    for (int w = 1; w <= 16; w++) window(1'b1);
    check("s5_pre_reset", o1, 5'b10001);
    do_reset();
    clr_counts();
    press_at = -1;
    hold_at = -1;
    for (int w = 1; w <= 20; w++) begin
      window(1'b1);
      if (o1[3] && press_at < 0) press_at = w;
      if (o1[0] && hold_at < 0) hold_at = w;
    end
    check_int("s5_press_tick", press_at, 4);
    check_int("s5_hold_tick", hold_at, 14);
    check_int("s5_presses", n_press, 1);
    for (int i = 0; i < 6; i++) window(1'b0);
    for (int k = 0; k < 4000;) begin
      int len;
      logic p;
      len = $urandom_range(1, 120);
      p = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) begin
        step(p, $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 999) == 0) do_reset();
      end
      k += len;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
